// File: rtl/alu_65ce02_mb.sv
// Multi-byte 65CE02-style ALU: one byte per RDY-enabled cycle, carry and
// half carry chained between bytes, optional BCD correction, whole-word
// N/Z/V/C flags, start/busy/done handshake towards the sequencer.
module alu_65ce02_mb #(
    parameter int unsigned BYTES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 RDY,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic                 right,
    input  logic                 arith,
    input  logic                 BCD,
    input  logic                 CI,
    input  logic [8*BYTES-1:0]   AI,
    input  logic [8*BYTES-1:0]   BI,
    output logic                 busy,
    output logic                 done,
    output logic [8*BYTES-1:0]   OUT,
    output logic                 CO,
    output logic                 V,
    output logic                 N,
    output logic                 Z,
    output logic                 HC
);

    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_DBL = 4'b1011;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  res_q, res_d;
    logic          done_q, done_d;
    logic [W-1:0]  out_q, out_d;
    logic          co_q, co_d, v_q, v_d, n_q, n_d, z_q, z_d, hc_q, hc_d;

    // operands and controls captured at accept
    logic [W-1:0]  a_q, b_q;
    logic [3:0]    op_q;
    logic          right_q, arith_q, bcd_q, ci_q;

    // byte-slice datapath
    logic [IW-1:0] pos;
    int unsigned   base;
    logic [7:0]    a_byte, b_byte, byte_out;
    logic          is_arith, is_sub, is_dbl, bcd_add, bcd_sub;
    logic          cin, hc_n, carry_next, fill, b_msb;
    logic [4:0]    lo, hi;
    logic [3:0]    lo_fix, hi_fix;
    logic [W-1:0]  res_full;

    // Current byte: right shifts walk MSB first, everything else LSB first.
    always_comb begin
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_DBL);
        is_sub   = (op_q == OP_SUB);
        is_dbl   = (op_q == OP_DBL);
        bcd_add  = bcd_q && (op_q == OP_ADD);
        bcd_sub  = bcd_q && is_sub;

        pos    = right_q ? (LAST - idx_q) : idx_q;
        base   = 32'(pos) << 3;
        a_byte = a_q[base +: 8];
        b_byte = is_sub ? ~b_q[base +: 8] : (is_dbl ? a_byte : b_q[base +: 8]);
        cin    = (idx_q == '0) ? (is_arith & ci_q) : carry_q;

        // low nibble, decimal fix-up forces the half carry on add
        lo     = {1'b0, a_byte[3:0]} + {1'b0, b_byte[3:0]} + {4'b0, cin};
        lo_fix = lo[3:0];
        hc_n   = lo[4];
        if (bcd_add && (lo > 5'd9)) begin
            lo_fix = lo[3:0] + 4'd6;
            hc_n   = 1'b1;
        end else if (bcd_sub && !lo[4]) begin
            lo_fix = lo[3:0] - 4'd6;
        end

        // high nibble, same rule with the half carry chained in
        hi         = {1'b0, a_byte[7:4]} + {1'b0, b_byte[7:4]} + {4'b0, hc_n};
        hi_fix     = hi[3:0];
        carry_next = hi[4];
        if (bcd_add && (hi > 5'd9)) begin
            hi_fix     = hi[3:0] + 4'd6;
            carry_next = 1'b1;
        end else if (bcd_sub && !hi[4]) begin
            hi_fix = hi[3:0] - 4'd6;
        end

        fill = (idx_q == '0) ? (arith_q ? a_q[W-1] : ci_q) : carry_q;

        if (right_q) begin
            byte_out   = {fill, a_byte[7:1]};
            carry_next = a_byte[0];
        end else begin
            case (op_q)
                OP_ADD, OP_SUB, OP_DBL: byte_out = {hi_fix, lo_fix};
                OP_OR:                  byte_out = a_byte | b_q[base +: 8];
                OP_AND:                 byte_out = a_byte & b_q[base +: 8];
                OP_XOR:                 byte_out = a_byte ^ b_q[base +: 8];
                default:                byte_out = a_byte;
            endcase
            if (!is_arith) carry_next = 1'b0;
        end

        res_full             = res_q;
        res_full[base +: 8]  = byte_out;
        b_msb = is_sub ? ~b_q[W-1] : (is_dbl ? a_q[W-1] : b_q[W-1]);
    end

    // Sequencer next state: accept in IDLE, one byte per step in RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        done_d  = 1'b0;
        out_d   = out_q;
        co_d    = co_q;
        v_d     = v_q;
        n_d     = n_q;
        z_d     = z_q;
        hc_d    = hc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                end
            end
            default: begin
                res_d   = res_full;
                carry_d = carry_next;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    out_d   = res_full;
                    co_d    = carry_next;
                    n_d     = res_full[W-1];
                    z_d     = (res_full == '0);
                    if (is_arith && !right_q) begin
                        v_d  = (a_q[W-1] ^ res_full[W-1]) & (b_msb ^ res_full[W-1]);
                        hc_d = hc_n;
                    end else begin
                        v_d  = 1'b0;
                        hc_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // State registers; RDY low freezes everything, reset wins over RDY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            hc_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
            bcd_q   <= 1'b0;
            ci_q    <= 1'b0;
        end else if (RDY) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            done_q  <= done_d;
            out_q   <= out_d;
            co_q    <= co_d;
            v_q     <= v_d;
            n_q     <= n_d;
            z_q     <= z_d;
            hc_q    <= hc_d;
            if (state_q == S_IDLE && start) begin
                a_q     <= AI;
                b_q     <= BI;
                op_q    <= op;
                right_q <= right;
                arith_q <= arith;
                bcd_q   <= BCD;
                ci_q    <= CI;
            end
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign OUT  = out_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign HC   = hc_q;

endmodule

// File: tb/tb_alu_65ce02_mb.sv
// Bench for alu_65ce02_mb: scoreboard of expected word results pushed at
// issue and popped when done pulses, plus per-scenario inline checks.
module tb_alu_65ce02_mb;

    typedef struct packed {
        logic [15:0] out;
        logic        co, v, n, z, hc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        RDY = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0011;
    logic        right = 1'b0, arith = 1'b0, BCD = 1'b0, CI = 1'b0;
    logic [15:0] AI = '0, BI = '0;
    logic        busy, done, CO, V, N, Z, HC;
    logic [15:0] OUT;

    logic        start4 = 1'b0;
    logic [31:0] AI4 = '0, BI4 = '0;
    logic        busy4, done4, CO4, V4, N4, Z4, HC4;
    logic [31:0] OUT4;

    int checks = 0;
    int passes = 0;
    exp_t  sbq[$];
    string nameq[$];
    logic  prev_done = 1'b0, prev_rdy = 1'b1;

    always #5 clk = ~clk;

    alu_65ce02_mb #(.BYTES(2)) dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .op(op),
        .right(right), .arith(arith), .BCD(BCD), .CI(CI), .AI(AI), .BI(BI),
        .busy(busy), .done(done), .OUT(OUT), .CO(CO), .V(V), .N(N), .Z(Z), .HC(HC)
    );

    alu_65ce02_mb #(.BYTES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start4), .op(op),
        .right(right), .arith(arith), .BCD(BCD), .CI(CI), .AI(AI4), .BI(BI4),
        .busy(busy4), .done(done4), .OUT(OUT4), .CO(CO4), .V(V4), .N(N4), .Z(Z4), .HC(HC4)
    );

    // word-level reference: whole-word arithmetic, digit-serial decimal
    function automatic exp_t model(input logic [15:0] a, b, input logic [3:0] o,
                                   input logic r, ar, bcd, ci);
        exp_t e;
        logic [15:0] bb;
        logic [16:0] s;
        logic [12:0] h;
        logic [4:0]  d;
        logic        c;
        e = '0;
        if (r) begin
            e.out = {(ar ? a[15] : ci), a[15:1]};
            e.co  = a[0];
        end else if (o == 4'b0011 || o == 4'b0111 || o == 4'b1011) begin
            bb = (o == 4'b0111) ? ~b : ((o == 4'b1011) ? a : b);
            if (bcd && o != 4'b1011) begin
                c = ci;
                for (int unsigned i = 0; i < 4; i++) begin
                    d = {1'b0, a[i*4 +: 4]} + {1'b0, bb[i*4 +: 4]} + {4'b0, c};
                    if (o == 4'b0011) begin
                        c = (d > 5'd9);
                        if (c) d = d + 5'd6;
                    end else begin
                        c = d[4];
                        if (!c) d = d - 5'd6;
                    end
                    e.out[i*4 +: 4] = d[3:0];
                    if (i == 2) e.hc = c;
                end
                e.co = c;
            end else begin
                s = {1'b0, a} + {1'b0, bb} + {16'b0, ci};
                e.out = s[15:0];
                e.co  = s[16];
                h = {1'b0, a[11:0]} + {1'b0, bb[11:0]} + {12'b0, ci};
                e.hc = h[12];
            end
            e.v = (a[15] ^ e.out[15]) & (bb[15] ^ e.out[15]);
        end else begin
            case (o)
                4'b1100: e.out = a | b;
                4'b1101: e.out = a & b;
                4'b1110: e.out = a ^ b;
                default: e.out = a;
            endcase
        end
        e.n = e.out[15];
        e.z = (e.out == 16'h0000);
        return e;
    endfunction

    // scoreboard: one pop per done pulse (done may be held by RDY=0)
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done && (!prev_done || prev_rdy)) begin
            checks++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_done: got OUT=%h with no operation pending", OUT);
            end else begin
                e = sbq.pop_front();
                if ({OUT, CO, V, N, Z, HC} !== e)
                    $display("FAIL %s: got OUT=%h CO=%b V=%b N=%b Z=%b HC=%b, want OUT=%h CO=%b V=%b N=%b Z=%b HC=%b",
                             nameq[0], OUT, CO, V, N, Z, HC, e.out, e.co, e.v, e.n, e.z, e.hc);
                else
                    passes++;
                void'(nameq.pop_front());
            end
        end
        prev_done = done;
        prev_rdy  = RDY;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, b, input logic [3:0] o,
                         input logic r, ar, bcd, ci, input string nm);
        int n = 0;
        while (busy && n < 100) begin step(); n++; end
        if (n >= 100) begin
            checks++;
            $display("FAIL %s_issue: busy=%b after %0d cycles, want 0", nm, busy, n);
        end
        AI = a; BI = b; op = o; right = r; arith = ar; BCD = bcd; CI = ci;
        start = 1'b1;
        sbq.push_back(model(a, b, o, r, ar, bcd, ci));
        nameq.push_back(nm);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 60) begin step(); n++; end
        if (!done) begin
            checks++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", nm, done, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({busy, done, OUT, CO, V, N, Z, HC} !== 23'h0)
            $display("FAIL reset_state: got busy=%b done=%b OUT=%h flags=%b%b%b%b%b, want all 0",
                     busy, done, OUT, CO, V, N, Z, HC);
        else passes++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int n;
        issue(16'h12FF, 16'h0001, 4'b0011, 0, 0, 0, 0, "add_12ff");
        wait_done("add_12ff", n);
        checks++;
        if (n !== 2) $display("FAIL add_latency: got %0d cycles, want 2", n);
        else passes++;
        checks++;
        if ({OUT, CO, Z, V} !== {16'h1300, 3'b000})
            $display("FAIL add_12ff_inline: got OUT=%h CO=%b Z=%b V=%b, want 1300 0 0 0", OUT, CO, Z, V);
        else passes++;
        issue(16'h7FFF, 16'h0001, 4'b0011, 0, 0, 0, 0, "add_ovf");
        wait_done("add_ovf", n);
        checks++;
        if ({OUT, V, N} !== {16'h8000, 2'b11})
            $display("FAIL add_ovf_inline: got OUT=%h V=%b N=%b, want 8000 1 1", OUT, V, N);
        else passes++;
        issue(16'h8000, 16'h8000, 4'b0011, 0, 0, 0, 0, "add_wrap");
        issue(16'h0F80, 16'h0080, 4'b0011, 0, 0, 0, 1, "add_hc");
        wait_done("add_hc", n);
    endtask

    task automatic test_sub();
        int n;
        issue(16'h0000, 16'h0001, 4'b0111, 0, 0, 0, 1, "sub_neg");
        wait_done("sub_neg", n);
        checks++;
        if ({OUT, CO, N} !== {16'hFFFF, 2'b01})
            $display("FAIL sub_neg_inline: got OUT=%h CO=%b N=%b, want ffff 0 1", OUT, CO, N);
        else passes++;
        issue(16'h5000, 16'h1000, 4'b0111, 0, 0, 0, 1, "sub_pos");
        issue(16'h8000, 16'h0001, 4'b0111, 0, 0, 0, 1, "sub_ovf");
        issue(16'h1234, 16'h1234, 4'b0111, 0, 0, 0, 0, "sub_borrow_in");
        wait_done("sub_borrow_in", n);
    endtask

    task automatic test_bcd();
        int n;
        issue(16'h0999, 16'h0001, 4'b0011, 0, 0, 1, 0, "bcd_0999");
        wait_done("bcd_0999", n);
        checks++;
        if ({OUT, CO} !== {16'h1000, 1'b0})
            $display("FAIL bcd_0999_inline: got OUT=%h CO=%b, want 1000 0", OUT, CO);
        else passes++;
        issue(16'h9999, 16'h0001, 4'b0011, 0, 0, 1, 0, "bcd_9999");
        wait_done("bcd_9999", n);
        checks++;
        if ({OUT, CO, Z} !== {16'h0000, 2'b11})
            $display("FAIL bcd_9999_inline: got OUT=%h CO=%b Z=%b, want 0000 1 1", OUT, CO, Z);
        else passes++;
        issue(16'h1000, 16'h0001, 4'b0111, 0, 0, 1, 1, "bcd_sub");
        issue(16'h0000, 16'h0001, 4'b0111, 0, 0, 1, 1, "bcd_sub_wrap");
        issue(16'h0458, 16'h0277, 4'b0011, 0, 0, 1, 1, "bcd_add_ci");
        wait_done("bcd_add_ci", n);
    endtask

    task automatic test_shift();
        int n;
        issue(16'h0001, 16'h0000, 4'b0011, 1, 0, 0, 1, "shr_ci");
        wait_done("shr_ci", n);
        checks++;
        if ({OUT, CO} !== {16'h8000, 1'b1})
            $display("FAIL shr_ci_inline: got OUT=%h CO=%b, want 8000 1", OUT, CO);
        else passes++;
        issue(16'h8002, 16'h0000, 4'b1100, 1, 1, 0, 0, "shr_arith");
        wait_done("shr_arith", n);
        checks++;
        if ({OUT, CO} !== {16'hC001, 1'b0})
            $display("FAIL shr_arith_inline: got OUT=%h CO=%b, want c001 0", OUT, CO);
        else passes++;
        issue(16'hA5A5, 16'h0000, 4'b1101, 1, 0, 0, 0, "shr_logical");
        issue(16'h8001, 16'h0000, 4'b1011, 0, 0, 0, 1, "shl_dbl");
        wait_done("shl_dbl", n);
    endtask

    task automatic test_logic();
        int n;
        issue(16'hF0F0, 16'h0FF0, 4'b1100, 0, 0, 0, 1, "or");
        issue(16'hF0F0, 16'h0FF0, 4'b1101, 0, 0, 1, 1, "and");
        issue(16'hF0F0, 16'hF0F0, 4'b1110, 0, 0, 0, 1, "xor_zero");
        issue(16'h8421, 16'hFFFF, 4'b1111, 0, 0, 0, 1, "pass_a");
        wait_done("pass_a", n);
    endtask

    task automatic test_rdy_stall();
        int n;
        issue(16'h1234, 16'h4321, 4'b0011, 0, 0, 0, 0, "stall");
        step();
        RDY = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done} !== 2'b10)
            $display("FAIL stall_hold: got busy=%b done=%b, want 1 0", busy, done);
        else passes++;
        RDY = 1'b1;
        step();
        checks++;
        if ({done, OUT} !== {1'b1, 16'h5555})
            $display("FAIL stall_done: got done=%b OUT=%h, want 1 5555", done, OUT);
        else passes++;
        RDY = 1'b0;
        repeat (2) step();
        checks++;
        if (done !== 1'b1) $display("FAIL done_held: got done=%b, want 1", done);
        else passes++;
        RDY = 1'b1;
        step();
        checks++;
        if (done !== 1'b0) $display("FAIL done_drop: got done=%b, want 0", done);
        else passes++;
        n = 0;
    endtask

    task automatic test_busy_ignore();
        int n;
        issue(16'h1111, 16'h2222, 4'b0011, 0, 0, 0, 0, "busy_ignore");
        AI = 16'hFFFF; BI = 16'hFFFF; op = 4'b0111; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("busy_ignore", n);
        checks++;
        if (OUT !== 16'h3333) $display("FAIL busy_ignore_inline: got OUT=%h, want 3333", OUT);
        else passes++;
        repeat (4) step();
        checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL busy_ignore_idle: got busy=%b done=%b, want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_reset_midop();
        issue(16'h1234, 16'h0001, 4'b0011, 0, 0, 0, 0, "aborted");
        step();
        reset_n = 1'b0;
        step();
        checks++;
        if ({busy, done, OUT, CO, V, N, Z, HC} !== 23'h0)
            $display("FAIL reset_midop: got busy=%b done=%b OUT=%h flags=%b%b%b%b%b, want all 0",
                     busy, done, OUT, CO, V, N, Z, HC);
        else passes++;
        void'(sbq.pop_back());
        void'(nameq.pop_back());
        reset_n = 1'b1;
        repeat (4) step();
        checks++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_no_done: got busy=%b done=%b, want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [3:0] ops [7];
        ops = '{4'b0011, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        for (int i = 0; i < 12; i++) begin
            issue(16'($urandom), 16'($urandom), ops[$urandom_range(0, 6)],
                  ($urandom_range(0, 4) == 0), 1'($urandom), 1'b0, 1'($urandom), "b2b");
        end
        wait_done("b2b", n);
        step();
    endtask

    task automatic test_bytes4();
        int n = 0;
        op = 4'b0011; right = 1'b0; BCD = 1'b0; CI = 1'b0;
        AI4 = 32'hFFFF_FFFF; BI4 = 32'h0000_0001; start4 = 1'b1;
        step();
        start4 = 1'b0;
        while (!done4 && n < 60) begin step(); n++; end
        checks++;
        if (n !== 4) $display("FAIL bytes4_latency: got %0d cycles, want 4", n);
        else passes++;
        checks++;
        if ({OUT4, CO4, Z4, V4} !== {32'h0, 3'b110})
            $display("FAIL bytes4_result: got OUT=%h CO=%b Z=%b V=%b, want 00000000 1 1 0", OUT4, CO4, Z4, V4);
        else passes++;
        step();
    endtask

    initial begin
        int n;
        test_reset();
        test_add();
        test_sub();
        test_bcd();
        test_shift();
        test_logic();
        test_rdy_stall();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_bytes4();
        n = 0;
        while (sbq.size() != 0 && n < 100) begin step(); n++; end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d results still pending, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
